// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel strobe divider, X/Y scan counters and
// registered sync, visible-area and frame-marker outputs derived from them.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       pix_en,
    output logic [9:0] drawX,
    output logic [9:0] drawY,
    output logic       hs,
    output logic       vs,
    output logic       display_en,
    output logic       frame_start,
    output logic       vsync_toggle
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > 1024) begin : g_bad_h_total
        $error("vga_sync_gen: H_TOTAL %0d exceeds 1024", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_bad_v_total
        $error("vga_sync_gen: V_TOTAL %0d exceeds 1024", V_TOTAL);
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("vga_sync_gen: CLK_DIV %0d must be at least 2", CLK_DIV);
    end

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             de_nxt;
    logic             fs_nxt;
    logic             vt_flip;

    always_comb begin
        div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end

    always_comb begin
        x_nxt = drawX;
        y_nxt = drawY;
        if (pix_en) begin
            if (drawX == H_LAST) begin
                x_nxt = '0;
                y_nxt = (drawY == V_LAST) ? '0 : drawY + 10'd1;
            end else begin
                x_nxt = drawX + 10'd1;
            end
        end
    end

    // Derived outputs come from the next counter values so they land on the
    // same edge as the counters themselves.
    always_comb begin
        hs_nxt  = !((x_nxt >= HS_START) && (x_nxt <= HS_END));
        vs_nxt  = !((y_nxt >= VS_START) && (y_nxt <= VS_END));
        de_nxt  = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        fs_nxt  = pix_en && (x_nxt == '0) && (y_nxt == '0);
        vt_flip = pix_en && (x_nxt == '0) && (y_nxt == VS_START);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            div    <= div_nxt;
            pix_en <= (div_nxt == DIV_LAST);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            drawX        <= '0;
            drawY        <= '0;
            hs           <= 1'b1;
            vs           <= 1'b1;
            display_en   <= 1'b1;
            frame_start  <= 1'b0;
            vsync_toggle <= 1'b0;
        end else begin
            drawX        <= x_nxt;
            drawY        <= y_nxt;
            hs           <= hs_nxt;
            vs           <= vs_nxt;
            display_en   <= de_nxt;
            frame_start  <= fs_nxt;
            vsync_toggle <= vsync_toggle ^ vt_flip;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances (divide by 2 and 4) on a reduced raster,
// checked every cycle against an arithmetic model plus hand-computed points.
module tb_vga_sync_gen;

    localparam int unsigned HV = 8, HF = 2, HSW = 3, HB = 2;
    localparam int unsigned VV = 4, VF = 1, VSW = 2, VB = 1;
    localparam int unsigned HT = HV + HF + HSW + HB;   // 15
    localparam int unsigned VT = VV + VF + VSW + VB;   // 8
    localparam int unsigned FR = HT * VT;              // 120 pixels per frame
    localparam logic [25:0] RST_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    logic       pe2, hs2, vs2, de2, fs2, vt2;
    logic [9:0] x2, y2;
    logic       pe4, hs4, vs4, de4, fs4, vt4;
    logic [9:0] x4, y4;

    vga_sync_gen #(
        .CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut2 (
        .CLK(CLK), .RESET(RESET), .pix_en(pe2), .drawX(x2), .drawY(y2),
        .hs(hs2), .vs(vs2), .display_en(de2), .frame_start(fs2), .vsync_toggle(vt2)
    );

    vga_sync_gen #(
        .CLK_DIV(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) dut4 (
        .CLK(CLK), .RESET(RESET), .pix_en(pe4), .drawX(x4), .drawY(y4),
        .hs(hs4), .vs(vs4), .display_en(de4), .frame_start(fs4), .vsync_toggle(vt4)
    );

    always #5 CLK = ~CLK;

    // Edges seen since reset release; the model is a pure function of this.
    int unsigned n;
    always @(posedge CLK or posedge RESET) begin
        if (RESET) n <= 0;
        else       n <= n + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", name, act, exp, n, $time);
        end
    endtask

    function automatic logic [25:0] model(input int unsigned cyc, input int unsigned d);
        int unsigned p, x, y, t;
        logic pe, hs, vs, de, fs, vt;
        p  = cyc / d;
        x  = p % HT;
        y  = (p / HT) % VT;
        pe = (cyc % d) == d - 1;
        hs = !(x >= HV + HF && x < HV + HF + HSW);
        vs = !(y >= VV + VF && y < VV + VF + VSW);
        de = (x < HV) && (y < VV);
        fs = (p > 0) && (p % FR == 0) && (cyc % d == 0);
        t  = (VV + VF) * HT;
        vt = (p >= t) ? 1'(((p - t) / FR + 1) % 2) : 1'b0;
        return {pe, 10'(x), 10'(y), hs, vs, de, fs, vt};
    endfunction

    wire logic [25:0] v2 = {pe2, x2, y2, hs2, vs2, de2, fs2, vt2};
    wire logic [25:0] v4 = {pe4, x4, y4, hs4, vs4, de4, fs4, vt4};

    int unsigned prev_n = 0;
    logic prev_vs2 = 1'b1, prev_vt2 = 1'b0, prev_vs4 = 1'b1, prev_vt4 = 1'b0;
    int unsigned hs_low2 = 0, vs_low2 = 0, de_cnt2 = 0, fs_cnt2 = 0, fs_last2 = 0;
    int unsigned hs_low4 = 0, vs_low4 = 0, fs_cnt4 = 0, fs_last4 = 0;

    always @(negedge CLK) begin
        if (RESET === 1'b1 || RESET === 1'b0) begin
            check("dut2_outputs", 32'(v2), 32'(model(n, 2)));
            check("dut4_outputs", 32'(v4), 32'(model(n, 4)));
            if (n != 0 && n == prev_n + 1) begin
                check("dut2_toggle_at_vs_fall", 32'(vt2 != prev_vt2), 32'(prev_vs2 && !vs2));
                check("dut4_toggle_at_vs_fall", 32'(vt4 != prev_vt4), 32'(prev_vs4 && !vs4));
            end
            if (n >= 1 && n <= 720) begin
                hs_low2 <= hs_low2 + 32'(!hs2);
                vs_low2 <= vs_low2 + 32'(!vs2);
                de_cnt2 <= de_cnt2 + 32'(de2);
                fs_cnt2 <= fs_cnt2 + 32'(fs2);
            end
            if (n >= 1 && n <= 960) begin
                hs_low4 <= hs_low4 + 32'(!hs4);
                vs_low4 <= vs_low4 + 32'(!vs4);
                fs_cnt4 <= fs_cnt4 + 32'(fs4);
            end
            if (fs2 && fs_last2 != 0) check("dut2_frame_spacing", n - fs_last2, 240);
            if (fs2) fs_last2 <= n;
            if (fs4 && fs_last4 != 0) check("dut4_frame_spacing", n - fs_last4, 480);
            if (fs4) fs_last4 <= n;
            prev_n   <= n;
            prev_vs2 <= vs2;
            prev_vt2 <= vt2;
            prev_vs4 <= vs4;
            prev_vt4 <= vt4;
        end
    end

    task automatic wait_n(input int unsigned k);
        int unsigned guard;
        guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (n != k && guard < 5000);
        if (n != k) check("wait_bound", n, k);
    endtask

    initial begin
        #1 RESET = 1'b1;
        #1 check("reset_immediate_dut2", 32'(v2), 32'(RST_VEC));
        repeat (3) begin
            @(negedge CLK);
            check("reset_hold_dut2", 32'(v2), 32'(RST_VEC));
            check("reset_hold_dut4", 32'(v4), 32'(RST_VEC));
        end
        #1 RESET = 1'b0;

        wait_n(1);  check("pix_en_first_d2", 32'(pe2), 1); check("x_before_adv", 32'(x2), 0);
                    check("pix_en_n1_d4", 32'(pe4), 0);
        wait_n(2);  check("first_adv_x", 32'(x2), 1); check("pix_en_n2_d2", 32'(pe2), 0);
        wait_n(3);  check("pix_en_first_d4", 32'(pe4), 1); check("x_d4_n3", 32'(x4), 0);
        wait_n(4);  check("first_adv_x_d4", 32'(x4), 1); check("first_adv_y_d4", 32'(y4), 0);
        wait_n(15); check("de_last_visible", 32'(de2), 1);
        wait_n(16); check("de_falls", 32'(de2), 0); check("x_at_de_fall", 32'(x2), 8);
        wait_n(19); check("hs_before_sync", 32'(hs2), 1);
        wait_n(20); check("hs_falls", 32'(hs2), 0); check("x_at_hs_fall", 32'(x2), 10);
        wait_n(28); check("x_line_end", 32'(x2), 14); check("y_line_end", 32'(y2), 0);
        wait_n(30); check("x_wrap", 32'(x2), 0); check("y_inc", 32'(y2), 1);
        wait_n(238); check("x_frame_end", 32'(x2), 14); check("y_frame_end", 32'(y2), 7);
        wait_n(240); check("frame_wrap", 32'({x2, y2, vs2, fs2}), 32'({10'd0, 10'd0, 1'b1, 1'b1}));
                     check("vt_after_frame1", 32'(vt2), 1);
        wait_n(241); check("fs_one_cycle", 32'(fs2), 0);
        wait_n(480); check("vt_after_frame2", 32'(vt2), 0);
        wait_n(720); check("vt_after_frame3", 32'(vt2), 1);
        wait_n(721);
        check("hs_low_3frames_d2", hs_low2, 144);
        check("vs_low_3frames_d2", vs_low2, 180);
        check("de_3frames_d2", de_cnt2, 192);
        check("fs_count_d2", fs_cnt2, 3);
        wait_n(961);
        check("hs_low_2frames_d4", hs_low4, 192);
        check("vs_low_2frames_d4", vs_low4, 240);
        check("fs_count_d4", fs_cnt4, 2);

        wait_n(1001);
        #3 RESET = 1'b1;
        #1 check("midop_reset_dut2", 32'(v2), 32'(RST_VEC));
        check("midop_reset_dut4", 32'(v4), 32'(RST_VEC));
        @(negedge CLK);
        #1 RESET = 1'b0;
        wait_n(2); check("resume_d2", 32'({x2, y2}), 32'({10'd1, 10'd0}));
        wait_n(4); check("resume_d4", 32'({x4, y4}), 32'({10'd1, 10'd0}));
        wait_n(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
